// File: rtl/uartin.sv
// uartin: 8N1 UART receiver feeding the byte FIFO through an active-low write strobe.
// Latency: 2 synchroniser cycles + floor(CDIV/2) + 9*CDIV (+CDIV with parity) + 1 from rx fall to n_wr low.
// Backpressure: n_full is sampled once, at the stop-bit sample; a full FIFO drops the byte and pulses ovr.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-high
//   rx       serial input, asynchronous to clk, idles high
//   n_full   FIFO status, low when the FIFO is full
//   port     last accepted byte, held until the next accepted byte
//   n_wr     FIFO write strobe, low for one cycle per accepted byte
//   ferr     framing-error pulse (stop bit sampled low)
//   ovr      overrun pulse (good byte dropped because the FIFO was full)
//   perr     parity-error pulse, present only with UARTIN_PARITY_EN
//
// Build option: define UARTIN_PARITY_EN for 8E1 frames (parity bit after bit 7,
// stop bit one bit time later, perr output added). Undefined gives plain 8N1.
module uartin #(
  parameter int CDIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       n_full,
  output logic [7:0] port,
  output logic       n_wr,
  output logic       ferr,
  output logic       ovr
`ifdef UARTIN_PARITY_EN
  ,
  output logic       perr
`endif
);

  localparam int CW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(CDIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CDIV - 1);
`ifdef UARTIN_PARITY_EN
  // Data bits 0..7 followed by the parity bit at index 8.
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_sync1;
  logic            r_sync2;
  logic            w_rxs;

  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_idx;
  logic [7:0]      r_shift;
`ifdef UARTIN_PARITY_EN
  logic            r_par;
  logic            w_par_bad;
  logic            w_perr;
`endif

  logic            w_tick_half;
  logic            w_tick_bit;
  logic            w_wr;
  logic            w_ferr;
  logic            w_ovr;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; reset to the idle line level so a reset does not
  // look like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // START waits half a bit to land on the middle of the start bit; every later
  // sample is one full bit time after the previous one.
  assign w_tick_half = (r_cnt == HALF);
  assign w_tick_bit  = (r_cnt == LAST);

`ifdef UARTIN_PARITY_EN
  // Even parity: data bits plus parity bit must have an even number of ones.
  assign w_par_bad = ^{r_shift, r_par};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_next = S_START;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (w_tick_half) begin
          w_next = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick_bit && (r_idx == LAST_IDX)) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit lets a start edge right after the nominal
        // stop-bit end be caught.
        if (w_tick_bit) begin
          w_next = w_rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line reports one ferr; wait here until it releases.
        if (w_rxs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decided at the stop-bit sample, registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr   = 1'b0;
    w_ferr = 1'b0;
    w_ovr  = 1'b0;
`ifdef UARTIN_PARITY_EN
    w_perr = 1'b0;
`endif
    if ((r_state == S_STOP) && w_tick_bit) begin
      if (!w_rxs) begin
        // Framing error wins over a parity error on the same frame.
        w_ferr = 1'b1;
`ifdef UARTIN_PARITY_EN
      end else if (w_par_bad) begin
        w_perr = 1'b1;
`endif
      end else if (n_full) begin
        w_wr = 1'b1;
      end else begin
        w_ovr = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timing counter, bit index and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_START:         r_cnt <= w_tick_half ? '0 : r_cnt + CW'(1);
        S_DATA, S_STOP:  r_cnt <= w_tick_bit  ? '0 : r_cnt + CW'(1);
        default:         r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (r_state != S_DATA) begin
      r_idx <= '0;
    end else if (w_tick_bit) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // LSB arrives first, so new bits enter at the top and shift down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if ((r_state == S_DATA) && w_tick_bit && !r_idx[3]) begin
      r_shift <= {w_rxs, r_shift[7:1]};
    end
  end

`ifdef UARTIN_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if ((r_state == S_DATA) && w_tick_bit && r_idx[3]) begin
      r_par <= w_rxs;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs: strobes are one-cycle pulses in the cycle after the
  // stop-bit sample; port is loaded on the same edge n_wr falls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port <= 8'h00;
      n_wr <= 1'b1;
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      n_wr <= ~w_wr;
      ferr <= w_ferr;
      ovr  <= w_ovr;
      if (w_wr) begin
        port <= r_shift;
      end
    end
  end

`ifdef UARTIN_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else begin
      perr <= w_perr;
    end
  end
`endif

endmodule
